// File: rtl/stream_pkg.sv
// Shared definitions for the stream width converters (serializer and deserializer).
package stream_pkg;

   // Hand-encoded so that bit 0 of the state register is out_valid.
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   function automatic int clog2(input int value);
      int r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/stream_serializer.sv
// Width-down converter: one IN_WIDTH word per handshake, emitted as RATIO OUT_WIDTH beats
// with out_last on the final beat, at full throughput.
module stream_serializer
   import stream_pkg::*;
#(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last
);

   localparam bit BAD_WIDTH = (OUT_WIDTH <= 0) ||
                              ((IN_WIDTH % ((OUT_WIDTH > 0) ? OUT_WIDTH : 1)) != 0);
   localparam int RATIO = (OUT_WIDTH > 0) ? IN_WIDTH / OUT_WIDTH : 1;
   localparam int CW    = (RATIO > 1) ? clog2(RATIO) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

   if (BAD_WIDTH) begin : g_bad_width
      $error("stream_serializer: IN_WIDTH must be a nonzero multiple of OUT_WIDTH");
   end

   logic [0:0]          state;
   logic [CW-1:0]       cnt;
   logic [IN_WIDTH-1:0] hold;
   logic [IN_WIDTH-1:0] hold_next;
   logic                rx;
   logic                tx;

   assign out_valid = state[0];
   assign out_last  = (state == SEND) && (cnt == LAST_CNT);
   assign tx        = out_valid && out_ready;
   // Accepting on the last beat's handshake is what keeps words back-to-back.
   assign in_ready  = (state == IDLE) || (tx && out_last);
   assign rx        = in_valid && in_ready;

   assign out_data  = LSB_FIRST ? hold[OUT_WIDTH-1:0] : hold[IN_WIDTH-1 -: OUT_WIDTH];
   assign hold_next = LSB_FIRST ? (hold >> OUT_WIDTH) : (hold << OUT_WIDTH);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         hold  <= '0;
      end else if (state == IDLE) begin
         if (rx) begin
            state <= SEND;
            hold  <= in_data;
            cnt   <= '0;
         end
      end else if (tx) begin
         if (!out_last) begin
            cnt  <= cnt + CW'(1);
            hold <= hold_next;
         end else if (rx) begin
            hold <= in_data;
            cnt  <= '0;
         end else begin
            state <= IDLE;
            cnt   <= '0;
         end
      end
   end

endmodule
